// File: rtl/w0rm_core_pkg.sv
// Shared W0RM decode definitions: opcodes, field positions, decoded-instruction struct and decode function.
// Opcodes 0xD-0xF raise dec_illegal only when W0RM_DECODE_ILLEGAL_TRAP_EN is defined; otherwise they decode as NOP.
package w0rm_core_pkg;

  localparam int INST_WIDTH = 16;
  // Widest immediate is the branch offset: 12 bits shifted left by one.
  localparam int IMM_WIDTH  = 13;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [3:0]           rd;
    logic [3:0]           rs;
    logic [3:0]           rt;
    logic [IMM_WIDTH-1:0] imm;
    logic                 use_imm;
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
    logic                 illegal;
`endif
  } dec_inst_t;

  function automatic logic [3:0] field(input logic [INST_WIDTH-1:0] inst, input int lsb);
    return inst[lsb +: 4];
  endfunction

  function automatic dec_inst_t decode_inst(input logic [INST_WIDTH-1:0] inst);
    dec_inst_t  d;
    logic [3:0] op;
    op = field(inst, OP_LSB);
    // NOTE: combinational code assigns a full default first so no path leaves a field unassigned (no latches).
    d  = '0;
    if (op < OP_ADDI) begin
      d.opcode = op;
      d.rd     = field(inst, RD_LSB);
      d.rs     = field(inst, RS_LSB);
      d.rt     = field(inst, RT_LSB);
    end else begin
      case (op)
        OP_ADDI, OP_LDI: begin
          d.opcode  = op;
          d.rd      = field(inst, RD_LSB);
          d.rs      = (op == OP_ADDI) ? field(inst, RD_LSB) : 4'h0;
          d.imm     = {{(IMM_WIDTH-8){inst[7]}}, inst[7:0]};
          d.use_imm = 1'b1;
        end
        OP_LD, OP_ST: begin
          d.opcode  = op;
          d.rd      = field(inst, RD_LSB);
          d.rs      = field(inst, RS_LSB);
          d.imm     = {{(IMM_WIDTH-4){inst[3]}}, inst[3:0]};
          d.use_imm = 1'b1;
        end
        OP_BR: begin
          d.opcode  = op;
          d.imm     = {inst[11:0], 1'b0};
          d.use_imm = 1'b1;
        end
        default: begin
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
          d.opcode  = op;
          d.rd      = field(inst, RD_LSB);
          d.rs      = field(inst, RS_LSB);
          d.rt      = field(inst, RT_LSB);
          d.illegal = 1'b1;
`endif
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/w0rm_core_skid_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle clear; absorbs fetches still in flight.
// Callers gate push/pop so a push only happens when a slot is free (or freed by a same-cycle pop).
module w0rm_core_skid_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // NOTE: storage is deliberately not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/w0rm_core_decode.sv
// W0RM decode stage: skid-buffers fetched words with their PC, decodes the head and registers it for execute.
// Optional macro W0RM_DECODE_ILLEGAL_TRAP_EN adds the dec_illegal output for opcodes 0xD-0xF.
module w0rm_core_decode #(
  parameter int                DATA_WIDTH = 32,
  parameter int                INST_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] START_PC = 32'h2000_0000,
  parameter int                FIFO_DEPTH = 4,
  parameter int                SKID       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [INST_WIDTH-1:0] inst_data_in,
  input  logic                  inst_valid_in,
  output logic                  decode_ready,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc,
  input  logic                  exec_ready,
  output logic                  dec_valid,
  output logic [DATA_WIDTH-1:0] dec_pc,
  output logic [3:0]            dec_opcode,
  output logic [3:0]            dec_rd,
  output logic [3:0]            dec_rs,
  output logic [3:0]            dec_rt,
  output logic [DATA_WIDTH-1:0] dec_imm,
  output logic                  dec_use_imm,
  output logic                  dec_overflow
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                  dec_illegal
`endif
);

  import w0rm_core_pkg::*;

  localparam int ENTRY_W = DATA_WIDTH + INST_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] pc_cnt;
  logic                  push, pop, drop, full, empty;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [ENTRY_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_pc;
  dec_inst_t             head_dec;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop       = !empty && (!dec_valid || exec_ready) && !flush;
  assign push      = inst_valid_in && !flush && (!full || pop);
  assign drop      = inst_valid_in && !flush && full && !pop;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign head_pc   = head[ENTRY_W-1 -: DATA_WIDTH];
  assign head_dec  = decode_inst(head[INST_WIDTH-1:0]);

  w0rm_core_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({pc_cnt, inst_data_in}),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_cnt       <= START_PC;
      decode_ready <= 1'b0;
      dec_overflow <= 1'b0;
    end else if (flush) begin
      pc_cnt       <= flush_pc;
      decode_ready <= 1'b1;
    end else begin
      if (push) pc_cnt <= pc_cnt + DATA_WIDTH'(2);
      // Keep SKID slots spare for fetches already issued when ready drops.
      decode_ready <= (FIFO_DEPTH - int'(count_nxt)) > SKID;
      if (drop) dec_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid   <= 1'b0;
      dec_pc      <= '0;
      dec_opcode  <= '0;
      dec_rd      <= '0;
      dec_rs      <= '0;
      dec_rt      <= '0;
      dec_imm     <= '0;
      dec_use_imm <= 1'b0;
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
      dec_illegal <= 1'b0;
`endif
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (pop) begin
      dec_valid   <= 1'b1;
      dec_pc      <= head_pc;
      dec_opcode  <= head_dec.opcode;
      dec_rd      <= head_dec.rd;
      dec_rs      <= head_dec.rs;
      dec_rt      <= head_dec.rt;
      dec_imm     <= {{(DATA_WIDTH-IMM_WIDTH){head_dec.imm[IMM_WIDTH-1]}}, head_dec.imm};
      dec_use_imm <= head_dec.use_imm;
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
      dec_illegal <= head_dec.illegal;
`endif
    end else if (exec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w0rm_core_decode.sv
// Directed self-checking bench for w0rm_core_decode: latency, decode, stall/overflow, flush and async reset.
module tb_w0rm_core_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] inst_data_in;
  logic        inst_valid_in;
  logic        decode_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        exec_ready;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [3:0]  dec_opcode, dec_rd, dec_rs, dec_rt;
  logic [31:0] dec_imm;
  logic        dec_use_imm;
  logic        dec_overflow;
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
  logic        dec_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  w0rm_core_decode dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inst_data_in  (inst_data_in),
    .inst_valid_in (inst_valid_in),
    .decode_ready  (decode_ready),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .exec_ready    (exec_ready),
    .dec_valid     (dec_valid),
    .dec_pc        (dec_pc),
    .dec_opcode    (dec_opcode),
    .dec_rd        (dec_rd),
    .dec_rs        (dec_rs),
    .dec_rt        (dec_rt),
    .dec_imm       (dec_imm),
    .dec_use_imm   (dec_use_imm),
    .dec_overflow  (dec_overflow)
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
    ,
    .dec_illegal   (dec_illegal)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    inst_data_in  = w;
    inst_valid_in = 1'b1;
    tick();
    inst_valid_in = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [3:0] op,
                         input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [31:0] imm, input logic use_imm);
    chk({tag, ".valid"}, dec_valid, 1'b1);
    chk({tag, ".pc"}, dec_pc, pc);
    chk({tag, ".op"}, dec_opcode, op);
    chk({tag, ".rd"}, dec_rd, rd);
    chk({tag, ".rs"}, dec_rs, rs);
    chk({tag, ".rt"}, dec_rt, rt);
    chk({tag, ".imm"}, dec_imm, imm);
    chk({tag, ".use_imm"}, dec_use_imm, use_imm);
  endtask

  initial begin
    reset_n       = 1'b0;
    inst_data_in  = '0;
    inst_valid_in = 1'b0;
    flush         = 1'b0;
    flush_pc      = '0;
    exec_ready    = 1'b0;
    #1;
    chk("rst.valid", dec_valid, 1'b0);
    chk("rst.ready", decode_ready, 1'b0);
    chk("rst.ovf", dec_overflow, 1'b0);
    chk("rst.pc", dec_pc, 32'h0);
    chk("rst.imm", dec_imm, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel.ready", decode_ready, 1'b1);

    // Two-cycle latency, R-type fields.
    exec_ready = 1'b1;
    push_word(16'h1234);
    chk("lat.valid_c1", dec_valid, 1'b0);
    tick();
    chk_dec("rtype", 32'h2000_0000, 4'h1, 4'h2, 4'h3, 4'h4, 32'h0, 1'b0);

    push_word(16'h88FF);
    tick();
    chk_dec("addi", 32'h2000_0002, 4'h8, 4'h8, 4'h8, 4'h0, 32'hFFFF_FFFF, 1'b1);

    push_word(16'hC800);
    tick();
    chk_dec("br", 32'h2000_0004, 4'hC, 4'h0, 4'h0, 4'h0, 32'hFFFF_F000, 1'b1);

    push_word(16'hA12F);
    tick();
    chk_dec("ld", 32'h2000_0006, 4'hA, 4'h1, 4'h2, 4'h0, 32'hFFFF_FFFF, 1'b1);

    push_word(16'hE123);
    tick();
`ifdef W0RM_DECODE_ILLEGAL_TRAP_EN
    chk_dec("illegal", 32'h2000_0008, 4'hE, 4'h1, 4'h2, 4'h3, 32'h0, 1'b0);
    chk("illegal.flag", dec_illegal, 1'b1);
`else
    chk_dec("nop", 32'h2000_0008, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
`endif

    // Stall: fill the FIFO behind a held output.
    exec_ready = 1'b0;
    push_word(16'h1111);
    chk("stall.ready1", decode_ready, 1'b1);
    push_word(16'h2222);
    chk("stall.ready2", decode_ready, 1'b0);
    chk("stall.hold_pc", dec_pc, 32'h2000_0008);
    push_word(16'h3333);
    push_word(16'h4444);
    chk("stall.valid", dec_valid, 1'b1);
    chk("stall.hold_pc4", dec_pc, 32'h2000_0008);
    chk("stall.ovf0", dec_overflow, 1'b0);

    // Push into full FIFO with a simultaneous pop is accepted.
    exec_ready = 1'b1;
    push_word(16'h5555);
    chk("fullpp.pc", dec_pc, 32'h2000_000A);
    chk("fullpp.op", dec_opcode, 4'h1);
    chk("fullpp.ovf", dec_overflow, 1'b0);
    chk("fullpp.ready", decode_ready, 1'b0);

    // Push into full FIFO without a pop is dropped and sets overflow.
    exec_ready = 1'b0;
    push_word(16'h6666);
    chk("ovf.set", dec_overflow, 1'b1);
    chk("ovf.hold_pc", dec_pc, 32'h2000_000A);

    exec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain%0d.pc", i), dec_pc, 32'h2000_000C + 32'(2 * i));
      chk($sformatf("drain%0d.op", i), dec_opcode, 4'(2 + i));
    end
    chk("drain.ready", decode_ready, 1'b1);
    tick();
    chk("drain.empty", dec_valid, 1'b0);

    // Dropped word must not have advanced the PC.
    push_word(16'h7000);
    tick();
    chk("pcskip.pc", dec_pc, 32'h2000_0014);
    chk("pcskip.op", dec_opcode, 4'h7);
    chk("ovf.sticky", dec_overflow, 1'b1);

    // Flush with a buffered word and a same-cycle arrival.
    exec_ready = 1'b0;
    push_word(16'h1AAA);
    flush         = 1'b1;
    flush_pc      = 32'h2000_0100;
    inst_data_in  = 16'h2BBB;
    inst_valid_in = 1'b1;
    tick();
    flush         = 1'b0;
    inst_valid_in = 1'b0;
    chk("flush.valid", dec_valid, 1'b0);
    chk("flush.ready", decode_ready, 1'b1);
    exec_ready = 1'b1;
    tick();
    chk("flush.drained", dec_valid, 1'b0);
    push_word(16'h3CCC);
    tick();
    chk("flush.pc", dec_pc, 32'h2000_0100);
    chk("flush.op", dec_opcode, 4'h3);

    // Asynchronous reset while output is stalled.
    exec_ready = 1'b0;
    push_word(16'h4DDD);
    chk("arst.pre_valid", dec_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.valid", dec_valid, 1'b0);
    chk("arst.pc", dec_pc, 32'h0);
    chk("arst.op", dec_opcode, 4'h0);
    chk("arst.ovf", dec_overflow, 1'b0);
    chk("arst.ready", decode_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst.rel_ready", decode_ready, 1'b1);
    push_word(16'h5EEE);
    exec_ready = 1'b1;
    tick();
    chk("arst.pc_restart", dec_pc, 32'h2000_0000);
    chk("arst.op_restart", dec_opcode, 4'h5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w0rm_core_decode.md
Name: w0rm_core_decode

Overview:
- Decode stage directly downstream of the W0RM instruction-fetch stage.
- Accepts 16-bit instruction words returned from instruction memory and buffers them in a small skid FIFO that absorbs in-flight fetches.
- Tracks the PC of each instruction and splits it into opcode, register addresses and sign-extended immediate.
- Presents one decoded instruction per cycle to execute over a valid/ready handshake; drives decode_ready back to fetch as the fetch-permission signal.

Parameters:
- DATA_WIDTH, 32, datapath/PC width
- INST_WIDTH, 16, instruction width
- START_PC, 32'h2000_0000, PC of first instruction after reset
- FIFO_DEPTH, 4, skid FIFO entries (power of 2, >= SKID+1)
- SKID, 2, maximum fetches in flight after decode_ready drops

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- inst_data_in  in  INST_WIDTH  instruction word from fetch
- inst_valid_in  in  1  inst_data_in valid this cycle
- decode_ready  out  1  fetch may issue a new request
- flush  in  1  branch taken in execute; discard all buffered/decoded state
- flush_pc  in  DATA_WIDTH  PC of the next instruction after flush
- exec_ready  in  1  execute accepts dec_valid this cycle
- dec_valid  out  1  decoded instruction valid
- dec_pc  out  DATA_WIDTH  PC of decoded instruction
- dec_opcode  out  4  opcode [15:12]
- dec_rd  out  4  destination register [11:8]
- dec_rs  out  4  source A [7:4]
- dec_rt  out  4  source B [3:0]
- dec_imm  out  DATA_WIDTH  sign-extended immediate
- dec_use_imm  out  1  operand B is dec_imm
- dec_overflow  out  1  sticky: instruction arrived with FIFO full

Behaviour:
- Reset (async, reset_n=0):
  - FIFO count=0; pc_cnt=START_PC.
  - dec_valid=0; all dec_* fields=0.
  - decode_ready=0; dec_overflow=0.
- decode_ready is registered: 1 when free entries after this cycle's push/pop > SKID, else 0. First cycle after reset release: 1.
- Push: inst_valid_in && !flush && count<FIFO_DEPTH writes {pc_cnt, inst_data_in}; pc_cnt += 2 (wraps modulo 2^DATA_WIDTH).
- Push with count==FIFO_DEPTH: word dropped, pc_cnt unchanged, dec_overflow set until reset.
- Output register: loads from FIFO head when count>0 and (!dec_valid || exec_ready). Pop and load occur in that same cycle.
- Pipeline latency: inst_valid_in to dec_valid is 2 cycles when FIFO empty and output free (push cycle, then load cycle).
- While dec_valid && !exec_ready, all dec_* outputs hold stable.
- Simultaneous push and pop with count==FIFO_DEPTH: pop frees a slot, so the push succeeds; no overflow.
- Decode (combinational on FIFO head, registered into dec_*):
  - 0x0–0x7 R-type: rd, rs, rt from fields; dec_use_imm=0; dec_imm=0.
  - 0x8 ADDI, 0x9 LDI: imm = sext(inst[7:0]); dec_rs=rd field for ADDI; rt=0; dec_use_imm=1.
  - 0xA LD, 0xB ST: rd, rs from fields; imm = sext(inst[3:0]); dec_use_imm=1.
  - 0xC BR: imm = sext(inst[11:0])<<1; rd=rs=rt=0; dec_use_imm=1.
  - 0xD–0xF: see Optional Feature.
- Flush (highest priority after reset):
  - Next edge: count=0; dec_valid=0; pc_cnt=flush_pc; decode_ready=1.
  - inst_valid_in during the flush cycle is discarded.
  - Fetch's flush guarantees no stale returns after the flush cycle.
- Reset mid-operation: all state cleared immediately regardless of handshake.

Optional Feature:
- Macro W0RM_DECODE_ILLEGAL_TRAP_EN.
- Defined: adds output dec_illegal (1 bit), registered alongside dec_valid; =1 for opcodes 0xD–0xF, fields passed through raw; reset 0.
- Undefined: opcodes 0xD–0xF decode as NOP (dec_opcode=0x0, rd=rs=rt=0, dec_use_imm=0); no dec_illegal port.

Decomposition:
- Shared package w0rm_core_pkg: opcode constants (OP_ADDI=4'h8, OP_LDI, OP_LD, OP_ST, OP_BR), field bit positions, decoded-instruction struct typedef, INST_WIDTH.
- One sub-module: w0rm_core_skid_fifo (parametrised synchronous FIFO with count, full/empty, flush clear).
- Field/immediate decode stays a function in the package.

Test Plan:
- Reset release, exec_ready=1, push 0x1234 at cycle 0 → dec_valid at cycle 2, dec_pc=0x2000_0000, opcode=1, rd=2, rs=3, rt=4.
- Push 0x88FF (ADDI r8,-1) → dec_imm=0xFFFF_FFFF, dec_rs=8, dec_use_imm=1.
- Push BR 0xC800 → dec_imm=0xFFFF_F000.
- exec_ready=0, push 4 words (FIFO_DEPTH=4) → decode_ready drops after count reaches 2; dec_* stable.
- Continue: a 5th push sets dec_overflow=1; release exec_ready → 4 words emerge in order, pcs +2 each.
- Mid-stream flush with flush_pc=0x2000_0100 and inst_valid_in=1 in the same cycle → next cycle dec_valid=0, count=0; that word dropped; next push gives dec_pc=0x2000_0100.
- Assert reset_n=0 asynchronously while dec_valid=1, exec_ready=0 → dec_valid=0 with no clock edge.
- With W0RM_DECODE_ILLEGAL_TRAP_EN: push 0xE123 → dec_illegal=1. Without the macro: dec_opcode=0, all fields 0.
